wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DATA_W, default 32: datapath width; multiple of 8, at least 16.
REQ-002 Parameter REG_ADDR_W, default 4: register-address width.
REQ-003 Parameter ZERO_REG_EN, default 1: when 1, writes to register 0 are suppressed.
REQ-004 Derived OFF_W = clog2(DATA_W/8): byte-offset width.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1  upstream presents an instruction result.
REQ-009 in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
REQ-010 alu_out  in  DATA_W  ALU result.
REQ-011 mem_out  in  DATA_W  raw memory read word.
REQ-012 pc_plus4  in  DATA_W  return address for calls.
REQ-013 reg_dest_in  in  REG_ADDR_W  destination register.
REQ-014 reg_wr_in  in  1  instruction writes a register.
REQ-015 wb_sel  in  2  source select: 00 ALU, 01 memory, 10 pc_plus4, 11 ALU.
REQ-016 ld_size  in  2  load size: 00 byte, 01 half, 10/11 full width.
REQ-017 ld_signed  in  1  sign-extend sub-word loads (1) or zero-extend (0).
REQ-018 ld_offset  in  OFF_W  byte address bits of the load.
REQ-019 flush  in  1  discard all held entries.
REQ-020 rf_ready  in  1  register-file write port free this cycle.
REQ-021 reg_wr_out  out  1  register-file write request.
REQ-022 reg_dest_out  out  REG_ADDR_W  write address.
REQ-023 reg_wr_data  out  DATA_W  write data.
REQ-024 retired_cnt  out  32  count of retired entries.

Function
REQ-025 Storage: output register (out_valid) plus one skid entry (skid_full); both capture data already resolved from inputs at acceptance.
REQ-026 Resolution at accept: wb_sel 01 byte takes lane mem_out[8*ld_offset +: 8]; half takes lane 16*(ld_offset>>1); full takes mem_out unchanged; sub-word results extended per ld_signed to DATA_W.
REQ-027 Effective write wr_eff = reg_wr_in && !(ZERO_REG_EN && reg_dest_in == 0), computed at accept.
REQ-028 reg_wr_out = out_valid && out_wr_eff; reg_dest_out and reg_wr_data driven from the output register only, held stable until retire.
REQ-029 Retire when out_valid && (!out_wr_eff || rf_ready); the write completes in the register file on that edge.
REQ-030 in_ready = !skid_full, registered; no combinational path from rf_ready to in_ready.
REQ-031 On accept: load the output register if it is empty or retiring this cycle, else load the skid entry.
REQ-032 When the output entry retires and the skid is full, the skid entry moves to the output register on the same edge.
REQ-033 Latency: accepted entry appears on outputs 1 cycle later when the stage is empty; order is strictly preserved.
REQ-034 retired_cnt increments by 1 per retire, wraps from 0xFFFFFFFF to 0; non-writing entries count.
REQ-035 Flush has priority: clears out_valid and skid_full and drops any same-cycle input; a write retiring in the flush cycle still completes and still counts.
REQ-036 No state machine beyond the states {EMPTY, ONE, FULL} implied by out_valid and skid_full; the state with skid_full && !out_valid is unreachable.

Reset
REQ-037 rst clears out_valid, skid_full and retired_cnt; in_ready = 1 and reg_wr_out = 0 from the first cycle after reset.
REQ-038 Reset mid-operation drops held entries without issuing writes; rst has priority over flush and input.

Verification
REQ-039 Byte load: wb_sel=01, mem_out=0x80FF1234, ld_size=00, ld_offset=3, ld_signed=1, reg_dest_in=5 -> next cycle reg_wr_out=1, reg_dest_out=5, reg_wr_data=0xFFFFFF80; with ld_signed=0 -> 0x00000080.
REQ-040 Backpressure: rf_ready=0, accept A then B -> in_ready=0 after B, outputs hold A; rf_ready=1 for 1 cycle -> A retires, B is on outputs next cycle, in_ready=1.
REQ-041 Zero register: reg_dest_in=0, reg_wr_in=1, rf_ready=0 -> reg_wr_out=0; entry retires in 1 cycle; retired_cnt +1.
REQ-042 Call: wb_sel=10, pc_plus4=0x00000104, alu_out=0xDEADBEEF -> reg_wr_data=0x00000104; half load with ld_offset=3, mem_out=0xABCD0000, ld_signed=0 -> 0x0000ABCD.
REQ-043 Flush while FULL with rf_ready=1 and in_valid=1 -> output-entry write issued, retired_cnt +1, next cycle out_valid=0, skid empty, input dropped.
REQ-044 Counter wrap: preload via 2^32-1 retires, or force the counter, then one retire -> retired_cnt=0; rst mid-FULL -> no writes, retired_cnt=0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: resolves load/ALU/return-address results at accept and
// drives a backpressured register-file write port through a two-entry buffer.
module wb_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_ADDR_W  = 4,
  parameter bit          ZERO_REG_EN = 1'b1,
  localparam int unsigned OFF_W      = $clog2(DATA_W / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic [DATA_W-1:0]     mem_out,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic [REG_ADDR_W-1:0] reg_dest_in,
  input  logic                  reg_wr_in,
  input  logic [1:0]            wb_sel,
  input  logic [1:0]            ld_size,
  input  logic                  ld_signed,
  input  logic [OFF_W-1:0]      ld_offset,
  input  logic                  flush,
  input  logic                  rf_ready,
  output logic                  reg_wr_out,
  output logic [REG_ADDR_W-1:0] reg_dest_out,
  output logic [DATA_W-1:0]     reg_wr_data,
  output logic [31:0]           retired_cnt
);

  typedef struct packed {
    logic                  wr_eff;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } entry_t;

  entry_t           out_q, skid_q, out_nxt, skid_nxt, in_ent;
  logic             out_valid, skid_full, out_valid_nxt, skid_full_nxt;
  logic [31:0]      cnt_nxt;
  logic             accept, retire;
  logic [OFF_W-1:0] half_off;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [DATA_W-1:0] ld_data;

  // Lane selection: byte at 8*offset, half at the aligned 16-bit lane.
  assign half_off = ld_offset & ~OFF_W'(1);
  assign ld_byte  = 8'(mem_out >> {ld_offset, 3'b000});
  assign ld_half  = 16'(mem_out >> {half_off, 3'b000});

  // Resolve the incoming result into a fully formed entry.
  always_comb begin
    ld_data = mem_out;
    case (ld_size)
      2'b00:   ld_data = {{(DATA_W-8){ld_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{(DATA_W-16){ld_signed & ld_half[15]}}, ld_half};
      default: ld_data = mem_out;
    endcase

    in_ent.wr_eff = reg_wr_in && !(ZERO_REG_EN && (reg_dest_in == '0));
    in_ent.dest   = reg_dest_in;
    case (wb_sel)
      2'b01:   in_ent.data = ld_data;
      2'b10:   in_ent.data = pc_plus4;
      default: in_ent.data = alu_out;
    endcase
  end

  // Next-state for the output register / skid pair and the retire counter.
  always_comb begin
    out_valid_nxt = out_valid;
    skid_full_nxt = skid_full;
    out_nxt       = out_q;
    skid_nxt      = skid_q;
    accept        = in_valid && !skid_full;
    retire        = out_valid && (!out_q.wr_eff || rf_ready);
    cnt_nxt       = retired_cnt + 32'(retire);

    if (flush) begin
      out_valid_nxt = 1'b0;
      skid_full_nxt = 1'b0;
    end else if (retire) begin
      if (skid_full) begin
        out_nxt       = skid_q;
        skid_full_nxt = 1'b0;
      end else if (accept) begin
        out_nxt = in_ent;
      end else begin
        out_valid_nxt = 1'b0;
      end
    end else if (accept) begin
      if (out_valid) begin
        skid_nxt      = in_ent;
        skid_full_nxt = 1'b1;
      end else begin
        out_nxt       = in_ent;
        out_valid_nxt = 1'b1;
      end
    end
  end

  // Control state is reset; payload registers only load behind valid flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      skid_full   <= 1'b0;
      in_ready    <= 1'b1;
      retired_cnt <= '0;
    end else begin
      out_valid   <= out_valid_nxt;
      skid_full   <= skid_full_nxt;
      in_ready    <= !skid_full_nxt;
      retired_cnt <= cnt_nxt;
    end
    out_q  <= out_nxt;
    skid_q <= skid_nxt;
  end

  assign reg_wr_out   = out_valid && out_q.wr_eff;
  assign reg_dest_out = out_q.dest;
  assign reg_wr_data  = out_q.data;

endmodule
